// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vector, load-use bubble insertion,
// multi-cycle EX timing, registered flush/redirect, and a saturating
// stall-cycle performance counter.
module pipe_ctrl #(
    parameter int unsigned CNT_W          = 6,
    parameter int unsigned PC_W           = 32,
    // Reset value of the stall-cycle counter; 0 in normal use.
    parameter logic [31:0] STALL_CNT_INIT = '0
) (
    input  logic             pipe_ctrl_clk,
    input  logic             pipe_ctrl_rst,
    input  logic             pipe_ctrl_stallreq_id_i,
    input  logic             pipe_ctrl_mc_start_i,
    input  logic [CNT_W-1:0] pipe_ctrl_mc_cycles_i,
    input  logic             pipe_ctrl_flush_i,
    input  logic [PC_W-1:0]  pipe_ctrl_new_pc_i,
    output logic [5:0]       pipe_ctrl_stall_o,
    output logic             pipe_ctrl_bubble_o,
    output logic             pipe_ctrl_flush_o,
    output logic [PC_W-1:0]  pipe_ctrl_new_pc_o,
    output logic             pipe_ctrl_mc_busy_o,
    output logic [31:0]      pipe_ctrl_stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    localparam logic [5:0] STALL_MC  = 6'b001111;
    localparam logic [5:0] STALL_LDU = 6'b000111;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and multi-cycle down-counter register.
    always_ff @(posedge pipe_ctrl_clk or negedge pipe_ctrl_rst) begin
        if (!pipe_ctrl_rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and stall/bubble/busy decode; flush overrides everything.
    always_comb begin
        state_nxt           = state;
        cnt_nxt             = cnt;
        pipe_ctrl_stall_o   = '0;
        pipe_ctrl_bubble_o  = 1'b0;
        pipe_ctrl_mc_busy_o = 1'b0;
        pipe_ctrl_flush_o   = (state == FLUSH);
        if (pipe_ctrl_flush_i) begin
            state_nxt = FLUSH;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (pipe_ctrl_mc_start_i) begin
                        // N<=1 completes in the start cycle; nothing to hold.
                        if (pipe_ctrl_mc_cycles_i >= CNT_W'(2)) begin
                            pipe_ctrl_stall_o   = STALL_MC;
                            pipe_ctrl_mc_busy_o = 1'b1;
                            cnt_nxt             = pipe_ctrl_mc_cycles_i - CNT_W'(2);
                            state_nxt           = MC_WAIT;
                        end
                    end else if (pipe_ctrl_stallreq_id_i) begin
                        pipe_ctrl_stall_o  = STALL_LDU;
                        pipe_ctrl_bubble_o = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pipe_ctrl_mc_busy_o = 1'b1;
                    if (cnt != '0) begin
                        pipe_ctrl_stall_o = STALL_MC;
                        cnt_nxt           = cnt - CNT_W'(1);
                    end else begin
                        state_nxt = RUN;
                    end
                end
                FLUSH: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // Redirect PC captured alongside each flush request.
    always_ff @(posedge pipe_ctrl_clk or negedge pipe_ctrl_rst) begin
        if (!pipe_ctrl_rst) begin
            pipe_ctrl_new_pc_o <= '0;
        end else if (pipe_ctrl_flush_i) begin
            pipe_ctrl_new_pc_o <= pipe_ctrl_new_pc_i;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge pipe_ctrl_clk or negedge pipe_ctrl_rst) begin
        if (!pipe_ctrl_rst) begin
            pipe_ctrl_stall_cnt_o <= STALL_CNT_INIT;
        end else if (pipe_ctrl_stall_o[0] && (pipe_ctrl_stall_cnt_o != '1)) begin
            pipe_ctrl_stall_cnt_o <= pipe_ctrl_stall_cnt_o + 32'd1;
        end
    end

endmodule
